// File: rtl/shooter_game_engine.sv
// Game-state engine for the shooter: synchronises the buttons and advances airplane, gun,
// bullet, hit detection, score and the PLAY/HIT/OVER state once per frame_tick.
module shooter_game_engine #(
  parameter int SCREEN_W    = 640,
  parameter int AIR_Y       = 40,
  parameter int AIR_W       = 32,
  parameter int AIR_H       = 16,
  parameter int AIR_STEP    = 2,
  parameter int GUN_Y       = 440,
  parameter int GUN_W       = 32,
  parameter int GUN_STEP    = 4,
  parameter int BULLET_W    = 4,
  parameter int BULLET_H    = 8,
  parameter int BULLET_STEP = 8,
  parameter int HIT_FRAMES  = 30,
  parameter int WIN_SCORE   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       bDer,
  input  logic       bIzq,
  input  logic       bCen,
  output logic [9:0] airplane_x,
  output logic [9:0] gun_x,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_on,
  output logic       col,
  output logic [4:0] score,
  output logic       finish
);

  localparam int          CW      = $clog2(HIT_FRAMES + 1);
  localparam logic [10:0] AIR_MAX = 11'(SCREEN_W - AIR_W);
  localparam logic [10:0] GUN_MAX = 11'(SCREEN_W - GUN_W);
  localparam logic [10:0] GUN_RST = 11'((SCREEN_W - GUN_W) / 2);
  localparam logic [10:0] A_STEP  = 11'(AIR_STEP);
  localparam logic [10:0] G_STEP  = 11'(GUN_STEP);
  localparam logic [10:0] B_STEP  = 11'(BULLET_STEP);
  localparam logic [10:0] B_OFS   = 11'(GUN_W / 2 - BULLET_W / 2);
  localparam logic [10:0] B_Y0    = 11'(GUN_Y - BULLET_H);

  typedef enum logic [1:0] {PLAY, HIT, OVER} state_t;
  state_t state_reg, state_next;

  logic [2:0]    sync1_reg, sync2_reg;
  logic          cen_prev_reg;
  logic          fire_rise, move_r, move_l, hit;
  logic [10:0]   air_x_reg, air_x_next, gun_x_reg, gun_x_next;
  logic [10:0]   bul_x_reg, bul_x_next, bul_y_reg, bul_y_next;
  logic          air_right_reg, air_right_next, bul_on_reg, bul_on_next;
  logic          fire_pending_reg, fire_pending_next;
  logic [4:0]    score_reg, score_next;
  logic [CW-1:0] hit_cnt_reg, hit_cnt_next;

  // Bit order of the synchroniser: [0]=right, [1]=left, [2]=fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      cen_prev_reg <= 1'b0;
    end else begin
      sync1_reg    <= {bCen, bIzq, bDer};
      sync2_reg    <= sync1_reg;
      cen_prev_reg <= sync2_reg[2];
    end
  end

  assign fire_rise = sync2_reg[2] & ~cen_prev_reg;
  assign move_r    = sync2_reg[0] & ~sync2_reg[1];
  assign move_l    = sync2_reg[1] & ~sync2_reg[0];

  assign hit = bul_on_reg
            && (bul_x_reg + 11'(BULLET_W) > air_x_reg)
            && (bul_x_reg < air_x_reg + 11'(AIR_W))
            && (bul_y_reg < 11'(AIR_Y + AIR_H))
            && (bul_y_reg + 11'(BULLET_H) > 11'(AIR_Y));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= PLAY;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (frame_tick) begin
      case (state_reg)
        PLAY:    if (hit) state_next = HIT;
        HIT:     if (hit_cnt_reg == CW'(1))
                   state_next = (score_reg >= 5'(WIN_SCORE)) ? OVER : PLAY;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    col        = (state_reg == HIT);
    finish     = (state_reg == OVER);
    airplane_x = air_x_reg[9:0];
    gun_x      = gun_x_reg[9:0];
    bullet_x   = bul_x_reg[9:0];
    bullet_y   = bul_y_reg[9:0];
    bullet_on  = bul_on_reg;
    score      = score_reg;
  end

  always_comb begin
    air_x_next        = air_x_reg;
    air_right_next    = air_right_reg;
    gun_x_next        = gun_x_reg;
    bul_x_next        = bul_x_reg;
    bul_y_next        = bul_y_reg;
    bul_on_next       = bul_on_reg;
    score_next        = score_reg;
    hit_cnt_next      = hit_cnt_reg;
    // A rising edge on the same cycle as a tick survives for the next frame.
    fire_pending_next = fire_rise | (fire_pending_reg & ~frame_tick);
    if (frame_tick && state_reg != OVER) begin
      if (move_r)
        gun_x_next = (gun_x_reg + G_STEP >= GUN_MAX) ? GUN_MAX : gun_x_reg + G_STEP;
      else if (move_l)
        gun_x_next = (gun_x_reg <= G_STEP) ? 11'd0 : gun_x_reg - G_STEP;
    end
    if (frame_tick && state_reg == PLAY) begin
      if (hit) begin
        bul_on_next  = 1'b0;
        score_next   = score_reg + 5'd1;
        hit_cnt_next = CW'(HIT_FRAMES);
      end else begin
        if (air_right_reg) begin
          if (air_x_reg + A_STEP >= AIR_MAX) begin
            air_x_next     = AIR_MAX;
            air_right_next = 1'b0;
          end else begin
            air_x_next = air_x_reg + A_STEP;
          end
        end else if (air_x_reg <= A_STEP) begin
          air_x_next     = 11'd0;
          air_right_next = 1'b1;
        end else begin
          air_x_next = air_x_reg - A_STEP;
        end
        if (bul_on_reg && bul_y_reg < B_STEP) begin
          bul_on_next = 1'b0;
        end else if (bul_on_reg) begin
          bul_y_next = bul_y_reg - B_STEP;
        end else if (fire_pending_reg) begin
          bul_on_next = 1'b1;
          bul_x_next  = gun_x_reg + B_OFS;
          bul_y_next  = B_Y0;
        end
      end
    end else if (frame_tick && state_reg == HIT) begin
      hit_cnt_next = (hit_cnt_reg == CW'(1)) ? '0 : hit_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      air_x_reg        <= '0;
      air_right_reg    <= 1'b1;
      gun_x_reg        <= GUN_RST;
      bul_x_reg        <= '0;
      bul_y_reg        <= '0;
      bul_on_reg       <= 1'b0;
      score_reg        <= '0;
      hit_cnt_reg      <= '0;
      fire_pending_reg <= 1'b0;
    end else begin
      air_x_reg        <= air_x_next;
      air_right_reg    <= air_right_next;
      gun_x_reg        <= gun_x_next;
      bul_x_reg        <= bul_x_next;
      bul_y_reg        <= bul_y_next;
      bul_on_reg       <= bul_on_next;
      score_reg        <= score_next;
      hit_cnt_reg      <= hit_cnt_next;
      fire_pending_reg <= fire_pending_next;
    end
  end

endmodule
